// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the pc_fetch block: FSM state encoding, the HLT opcode
// and the opcode field geometry, imported by the decoder and the datapath.
package pc_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      HALT
   } state_t;

   // The opcode occupies the top OPC_W bits of an instruction word.
   localparam int OPC_W = 5;
   localparam logic [OPC_W-1:0] OPC_HLT = 5'b00000;

   function automatic logic isHalt(input logic [OPC_W-1:0] opcode);
      return opcode == OPC_HLT;
   endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Program-memory / PC-adder / datapath bus of pc_fetch. The master side is the
// fetch unit; the slave side is the memory, the external adder and the datapath.
interface pc_fetch_if #(
   parameter int PC_W    = 11,
   parameter int INSTR_W = 16
);

   logic [PC_W-1:0]    pc_o;
   logic [PC_W-1:0]    pc_inc_i;
   logic [INSTR_W-1:0] instr_i;
   logic [INSTR_W-1:0] ir_o;
   logic               instr_valid_o;
   logic               ack_i;

   modport master (
      output pc_o, ir_o, instr_valid_o,
      input  pc_inc_i, instr_i, ack_i
   );

   modport slave (
      input  pc_o, ir_o, instr_valid_o,
      output pc_inc_i, instr_i, ack_i
   );

endinterface

// File: rtl/pc_fetch_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of
// wrapping so a long run never reports a small cycle count.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Clear wins over enable so a restart always begins from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch FSM: presents the PC, latches the returned word into ir_o,
// advances the PC from the external adder and hands the instruction to the datapath.
module pc_fetch import pc_fetch_pkg::*; #(
   parameter int PC_W    = 11,
   parameter int INSTR_W = 16,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   pc_fetch_if.master       bus,
   output logic             halted_o,
   output logic [CNT_W-1:0] cycle_cnt_o
);

   state_t             state_q;
   logic [PC_W-1:0]    pc_q;
   logic [INSTR_W-1:0] ir_q;
   logic               valid_q;
   logic               halted_q;

   logic               hltOp;
   logic               cntEn;
   logic               cntClr;

   assign hltOp = isHalt(bus.instr_i[INSTR_W-1 -: OPC_W]);

   // The PC only ever takes pc_inc_i (already modulo 2^PC_W) or zero on restart.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         ir_q     <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q <= FETCH;
               end
            end
            FETCH: begin
               state_q <= DECODE;
            end
            DECODE: begin
               ir_q <= bus.instr_i;
               if (hltOp) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end else begin
                  pc_q    <= bus.pc_inc_i;
                  state_q <= EXEC;
                  valid_q <= 1'b1;
               end
            end
            EXEC: begin
               if (bus.ack_i) begin
                  valid_q <= 1'b0;
                  state_q <= FETCH;
               end
            end
            HALT: begin
               if (start_i) begin
                  pc_q     <= '0;
                  ir_q     <= '0;
                  halted_q <= 1'b0;
                  state_q  <= FETCH;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // The DECODE cycle that retires into HALT is not an executed cycle.
   assign cntEn  = (state_q == FETCH) || (state_q == EXEC) ||
                   ((state_q == DECODE) && !hltOp);
   assign cntClr = (state_q == HALT) && start_i;

   sat_counter #(
      .W(CNT_W)
   ) u_cycleCnt (
      .clk   (clk),
      .reset (reset),
      .en_i  (cntEn),
      .clr_i (cntClr),
      .cnt_o (cycle_cnt_o)
   );

   assign bus.pc_o          = pc_q;
   assign bus.ir_o          = ir_q;
   assign bus.instr_valid_o = valid_q;
   assign halted_o          = halted_q;

endmodule
